// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART register responder: the byte-level protocol
// constants and the responder FSM state encoding, plus small state-class
// helpers used by the datapath.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Command bytes that open a packet.
    localparam logic [7:0] CMD_WR = 8'h57;   // 'W': CMD_WR, addr, data
    localparam logic [7:0] CMD_RD = 8'h52;   // 'R': CMD_RD, addr

    // Response bytes.
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_WR_EXEC,
        S_RD_EXEC,
        S_RD_WAIT,
        S_TX_REQ,
        S_TX_WAIT
    } state_t;

    // States that are waiting for the next byte of a packet (timeout applies).
    function automatic logic is_collect_state(input state_t s);
        return (s == S_GET_ADDR) || (s == S_GET_DATA);
    endfunction

    // States in which a response is in progress; bytes arriving here are dropped.
    function automatic logic is_busy_state(input state_t s);
        return (s == S_WR_EXEC) || (s == S_RD_EXEC) || (s == S_RD_WAIT) ||
               (s == S_TX_REQ)  || (s == S_TX_WAIT);
    endfunction

endpackage

// File: rtl/uart_edge_detect.sv
// -----------------------------------------------------------------------------
// uart_edge_detect
// Registered rising-edge detector. The history register is primed to 1 in
// reset so that a level that is already high when reset releases does not
// produce an edge.
//
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_sig    level input to watch
//   o_rise   one-cycle pulse, registered, the cycle after i_sig is first seen high
// -----------------------------------------------------------------------------
module uart_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b1;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/uart_reg_responder.sv
// -----------------------------------------------------------------------------
// uart_reg_responder
// Byte-level command responder behind a Uart8 instance. Decodes 2-byte read
// (CMD_RD, addr) and 3-byte write (CMD_WR, addr, data) packets, performs one
// access on a simple register bus and sends a single response byte: ACK for a
// write, the read data for a read, NAK for anything malformed. A packet whose
// next byte does not arrive within TIMEOUT_CYCLES idle cycles is discarded
// silently. Bytes arriving while a response is in progress are counted.
//
// Ports:
//   i_clk, i_reset      board clock, synchronous active-high reset
//   i_rxDone            Uart8 byte-received level (rising edge = new byte)
//   i_rxErr, i_rxByte   Uart8 frame error and received byte
//   i_txBusy            Uart8 transmitter busy
//   o_txStart, o_txByte transmit request (held until busy seen) and its byte
//   o_regAddr           register address (holds between accesses)
//   o_regWrData         register write data (holds between accesses)
//   o_regWe, o_regRe    one-cycle write / read strobes
//   i_regRdData         read data, valid the cycle after o_regRe
//   o_dropCount         saturating count of bytes dropped while busy
// -----------------------------------------------------------------------------
module uart_reg_responder
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rxDone,
    input  logic                  i_rxErr,
    input  logic [7:0]            i_rxByte,
    input  logic                  i_txBusy,
    output logic                  o_txStart,
    output logic [7:0]            o_txByte,
    output logic [ADDR_WIDTH-1:0] o_regAddr,
    output logic [7:0]            o_regWrData,
    output logic                  o_regWe,
    output logic                  o_regRe,
    input  logic [7:0]            i_regRdData,
    output logic [7:0]            o_dropCount
);

    localparam int            TIMER_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_event;
    logic [7:0]              r_rx_byte;
    logic                    r_rx_err;
    logic                    r_is_write;
    logic [TIMER_W-1:0]      r_timer;
    logic                    w_timeout;
    logic [7:0]              r_tx_byte;
    logic [ADDR_WIDTH-1:0]   r_reg_addr;
    logic [7:0]              r_wr_data;
    logic [7:0]              r_drop_count;
    logic                    w_reg_we;
    logic                    w_reg_re;
    logic                    w_tx_start;

    uart_edge_detect u_rx_done_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_rxDone),
        .o_rise  (w_event)
    );

    // The edge detector adds one register stage, so byte and error are
    // delayed by the same stage to line up with w_event.
    // NOTE: these capture registers carry no reset: they are only consumed
    // while w_event is high, and w_event itself is reset.
    always_ff @(posedge i_clk) begin
        r_rx_byte <= i_rxByte;
        r_rx_err  <= i_rxErr;
    end

    assign w_timeout = (r_timer == TIMEOUT_LAST);

    // Next-state and Moore strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement leaves one unassigned (no latches).
        w_next_state = r_state;
        w_reg_we     = 1'b0;
        w_reg_re     = 1'b0;
        w_tx_start   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    if (!r_rx_err && (r_rx_byte == CMD_WR || r_rx_byte == CMD_RD))
                        w_next_state = S_GET_ADDR;
                    else
                        w_next_state = S_TX_REQ;
                end
            end
            S_GET_ADDR: begin
                // A byte arriving on the expiry cycle takes priority.
                if (w_event) begin
                    if (r_rx_err)        w_next_state = S_TX_REQ;
                    else if (r_is_write) w_next_state = S_GET_DATA;
                    else                 w_next_state = S_RD_EXEC;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (w_event) begin
                    if (r_rx_err) w_next_state = S_TX_REQ;
                    else          w_next_state = S_WR_EXEC;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR_EXEC: begin
                w_reg_we     = 1'b1;
                w_next_state = S_TX_REQ;
            end
            S_RD_EXEC: begin
                w_reg_re     = 1'b1;
                w_next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_next_state = S_TX_REQ;
            end
            S_TX_REQ: begin
                w_tx_start = 1'b1;
                if (i_txBusy) w_next_state = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (!i_txBusy) w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and datapath.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_timer      <= '0;
            r_tx_byte    <= '0;
            r_reg_addr   <= '0;
            r_wr_data    <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_next_state;

            // Timer counts idle cycles between bytes of a packet only.
            if (w_event || !is_collect_state(r_state))
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;

            if (w_event && is_busy_state(r_state) && r_drop_count != 8'hFF)
                r_drop_count <= r_drop_count + 8'd1;

            if (w_event && r_state == S_IDLE)
                r_is_write <= (r_rx_byte == CMD_WR);

            if (w_event && r_state == S_GET_ADDR)
                r_reg_addr <= r_rx_byte[ADDR_WIDTH-1:0];

            if (w_event && r_state == S_GET_DATA)
                r_wr_data <= r_rx_byte;

            // Load the response byte on entry to TX_REQ only, so it stays
            // stable for the whole request/transmit handshake.
            if (w_next_state == S_TX_REQ && r_state != S_TX_REQ) begin
                case (r_state)
                    S_WR_EXEC: r_tx_byte <= ACK;
                    S_RD_WAIT: r_tx_byte <= i_regRdData;
                    default:   r_tx_byte <= NAK;
                endcase
            end
        end
    end

    assign o_txStart   = w_tx_start;
    assign o_txByte    = r_tx_byte;
    assign o_regAddr   = r_reg_addr;
    assign o_regWrData = r_wr_data;
    assign o_regWe     = w_reg_we;
    assign o_regRe     = w_reg_re;
    assign o_dropCount = r_drop_count;

endmodule

// File: tb/tb_uart_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_responder
// Self-checking bench for uart_reg_responder. A bench-side register slave and
// Uart8 transmitter stand-in record every strobe and response; a packet-level
// reference model predicts what each packet must produce.
// -----------------------------------------------------------------------------
module tb_uart_reg_responder;

    localparam int         T     = 20;      // TIMEOUT_CYCLES used for the DUT
    localparam logic [7:0] K_WR  = 8'h57;
    localparam logic [7:0] K_RD  = 8'h52;
    localparam logic [7:0] K_ACK = 8'h06;
    localparam logic [7:0] K_NAK = 8'h15;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_done   = 1'b1;
    logic       rx_err    = 1'b0;
    logic [7:0] rx_byte   = 8'h41;
    logic       tx_busy   = 1'b0;
    logic [7:0] rd_data   = 8'h00;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] drop_count;

    uart_reg_responder #(
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rxDone    (rx_done),
        .i_rxErr     (rx_err),
        .i_rxByte    (rx_byte),
        .i_txBusy    (tx_busy),
        .o_txStart   (tx_start),
        .o_txByte    (tx_byte),
        .o_regAddr   (reg_addr),
        .o_regWrData (reg_wr_data),
        .o_regWe     (reg_we),
        .o_regRe     (reg_re),
        .i_regRdData (rd_data),
        .o_dropCount (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Observation logs and bench-side peripherals.
    logic [15:0] q_wr[$];
    logic [7:0]  q_rd[$];
    logic [7:0]  q_tx[$];
    int          we_cyc, re_cyc, ts_cyc, last_raise;
    logic [7:0]  slave_mem [256];
    logic [7:0]  ref_mem   [256];
    bit          tx_auto   = 1'b1;
    int          tx_len    = 3;
    int          busy_left = 0;
    logic [7:0]  tx_hold;
    logic        prev_start = 1'b0;
    int          exp_drop   = 0;

    always @(negedge clk) begin
        if (reg_we) begin
            q_wr.push_back({reg_addr, reg_wr_data});
            we_cyc = cyc;
            slave_mem[reg_addr] = reg_wr_data;
        end
        if (reg_re) begin
            q_rd.push_back(reg_addr);
            re_cyc  = cyc;
            rd_data = slave_mem[reg_addr];
        end
        if (tx_start && !prev_start) begin
            q_tx.push_back(tx_byte);
            ts_cyc = cyc;
        end
        prev_start = tx_start;
        if (tx_auto) begin
            if (!tx_busy && tx_start) begin
                tx_busy   = 1'b1;
                busy_left = tx_len;
                tx_hold   = tx_byte;
            end else if (tx_busy) begin
                if (busy_left == 0) begin
                    check("tx_byte_stable", tx_byte, tx_hold);
                    tx_busy = 1'b0;
                end else begin
                    busy_left--;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        rx_byte    = b;
        rx_err     = e;
        rx_done    = 1'b1;
        last_raise = cyc;
        @(negedge clk);
        rx_done = 1'b0;
        rx_err  = 1'b0;
    endtask

    task automatic clear_logs();
        q_wr.delete();
        q_rd.delete();
        q_tx.delete();
        ts_cyc = -1000;
        we_cyc = -1000;
        re_cyc = -1000;
    endtask

    task automatic wait_quiet(input int bound);
        int k = 0;
        while (!(q_tx.size() > 0 && !tx_busy && !tx_start) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("response_within_bound", (k < bound) ? 1 : 0, 1);
        idle(3);
    endtask

    // Packet-level reference model: decide from the protocol rules how many
    // bytes the packet consumes and what it must produce, then send it.
    // Latencies are in cycles from the rxDone rise of the last byte.
    task automatic run_packet(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [2:0] errs,
                              input int gap);
        int         n;
        int         exp_lat;
        logic [7:0] exp_tx;
        int         exp_we;
        int         exp_re;
        exp_we = 0;
        exp_re = 0;
        if (errs[0] || (b0 != K_WR && b0 != K_RD)) begin
            n = 1; exp_tx = K_NAK; exp_lat = 2;
        end else if (errs[1]) begin
            n = 2; exp_tx = K_NAK; exp_lat = 2;
        end else if (b0 == K_RD) begin
            n = 2; exp_tx = ref_mem[b1]; exp_lat = 4; exp_re = 1;
        end else if (errs[2]) begin
            n = 3; exp_tx = K_NAK; exp_lat = 2;
        end else begin
            n = 3; exp_tx = K_ACK; exp_lat = 3; exp_we = 1;
            ref_mem[b1] = b2;
        end

        clear_logs();
        send_byte(b0, errs[0]);
        if (n > 1) begin idle(gap); send_byte(b1, errs[1]); end
        if (n > 2) begin idle(gap); send_byte(b2, errs[2]); end
        wait_quiet(100 + tx_len);

        check("tx_count", q_tx.size(), 1);
        if (q_tx.size() > 0) check("tx_byte", q_tx[0], exp_tx);
        check("tx_latency", ts_cyc - last_raise, exp_lat);
        check("we_count", q_wr.size(), exp_we);
        if (exp_we == 1 && q_wr.size() > 0) begin
            check("we_addr_data", q_wr[0], {b1, b2});
            check("we_latency", we_cyc - last_raise, 2);
        end
        check("re_count", q_rd.size(), exp_re);
        if (exp_re == 1 && q_rd.size() > 0) begin
            check("re_addr", q_rd[0], b1);
            check("re_latency", re_cyc - last_raise, 2);
        end
        check("drop_count", drop_count, exp_drop);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_txStart"},   tx_start,    0);
        check({pfx, "_txByte"},    tx_byte,     0);
        check({pfx, "_regAddr"},   reg_addr,    0);
        check({pfx, "_regWrData"}, reg_wr_data, 0);
        check({pfx, "_regWe"},     reg_we,      0);
        check({pfx, "_regRe"},     reg_re,      0);
        check({pfx, "_dropCount"}, drop_count,  0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [7:0] rb0, rb1, rb2;
    logic [2:0] rerr;
    int         kind;

    initial begin
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'($urandom);
            ref_mem[i]   = slave_mem[i];
        end
        clear_logs();

        // Reset with rxDone already high: no event may follow the release.
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        idle(8);
        check("primed_edge_no_tx", q_tx.size(), 0);
        rx_done = 1'b0;
        idle(3);

        // Directed packets.
        run_packet(K_WR, 8'h12, 8'hA5, 3'b000, 0);
        ref_mem[8'h34]   = 8'h5C;
        slave_mem[8'h34] = 8'h5C;
        run_packet(K_RD, 8'h34, 8'h00, 3'b000, 0);
        run_packet(8'h41, 8'h00, 8'h00, 3'b000, 0);
        run_packet(K_WR, 8'h12, 8'h77, 3'b010, 0);
        run_packet(K_RD, 8'h12, 8'h00, 3'b000, 0);

        // Randomized packets.
        for (int i = 0; i < 40; i++) begin
            kind   = $urandom_range(0, 4);
            rb0    = 8'($urandom);
            rb1    = 8'($urandom);
            rb2    = 8'($urandom);
            rerr   = 3'b000;
            tx_len = $urandom_range(1, 6);
            case (kind)
                0: rb0 = K_WR;
                1: rb0 = K_RD;
                2: ;
                3: begin rb0 = K_WR; rerr = 3'(1 << $urandom_range(0, 2)); end
                default: begin rb0 = K_RD; rerr = 3'(1 << $urandom_range(0, 1)); end
            endcase
            run_packet(rb0, rb1, rb2, rerr, $urandom_range(0, 3));
        end
        tx_len = 3;

        // Timeout: write abandoned after its address byte.
        clear_logs();
        send_byte(K_WR, 1'b0);
        idle(1);
        send_byte(8'h12, 1'b0);
        idle(T + 10);
        check("timeout_tx_count", q_tx.size(), 0);
        check("timeout_we_count", q_wr.size(), 0);
        check("timeout_re_count", q_rd.size(), 0);
        run_packet(K_RD, 8'h12, 8'h00, 3'b000, 0);

        // Longest allowed gap (T idle cycles between byte events) still works.
        run_packet(K_RD, 8'h21, 8'h00, 3'b000, T - 1);
        // One cycle more: the read is discarded, 0x12 becomes a bad command.
        clear_logs();
        send_byte(K_RD, 1'b0);
        idle(T);
        run_packet(8'h12, 8'h00, 8'h00, 3'b000, 0);

        // Overlap: three bytes while the transmitter is busy.
        tx_len = 60;
        clear_logs();
        send_byte(8'h41, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        exp_drop = (exp_drop + 3 > 255) ? 255 : exp_drop + 3;
        wait_quiet(200);
        check("overlap_tx_count", q_tx.size(), 1);
        if (q_tx.size() > 0) check("overlap_tx_byte", q_tx[0], K_NAK);
        check("overlap_we_re", q_wr.size() + q_rd.size(), 0);
        check("overlap_drop", drop_count, exp_drop);

        // Saturation: 297 more drops, 300 in total.
        tx_len = 1300;
        clear_logs();
        send_byte(8'h41, 1'b0);
        for (int i = 0; i < 252; i++) send_byte(8'($urandom), 1'b0);
        idle(2);
        check("drop_at_255", drop_count, (3 + 252 > 255) ? 255 : 3 + 252);
        for (int i = 0; i < 45; i++) send_byte(8'($urandom), 1'b0);
        idle(2);
        exp_drop = (300 > 255) ? 255 : 300;
        check("drop_saturated", drop_count, exp_drop);
        wait_quiet(1500);
        check("sat_tx_count", q_tx.size(), 1);
        check("sat_we_re", q_wr.size() + q_rd.size(), 0);

        // Reset while TX_REQ is held (transmitter never goes busy).
        tx_len  = 3;
        tx_auto = 1'b0;
        clear_logs();
        send_byte(8'h41, 1'b0);
        idle(4);
        check("txreq_held", tx_start, 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset    = 1'b0;
        exp_drop = 0;
        tx_auto  = 1'b1;
        idle(2);
        rb1 = 8'($urandom);
        rb2 = 8'($urandom);
        run_packet(K_WR, rb1, rb2, 3'b000, 1);
        run_packet(K_RD, rb1, 8'h00, 3'b000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
